// File: rtl/miriscv_data_ram.sv
// Behavioural data memory for the miriscv data interface: single outstanding access,
// programmable response latency. Define MIRISCV_DATA_RAM_BOUNDS_EN for out-of-range checking.
module miriscv_data_ram #(
    parameter int unsigned MEM_WORDS = 1024,
    parameter int unsigned LATENCY   = 1
) (
    input  logic        clk_i,
    input  logic        arst_i,
    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o
);

    localparam int unsigned AW       = $clog2(MEM_WORDS);
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]    state;
    logic [3:0]    cnt;
    logic [31:0]   rdata_q;
    logic [AW-1:0] word_idx;
    logic          in_range;
    logic          accept;
    logic          unused_addr;

    logic [31:0] mem [MEM_WORDS];

    assign word_idx    = data_addr_i[AW+1:2];
    assign accept      = (state == ST_IDLE) && data_req_i;
    assign unused_addr = ^{data_addr_i[1:0], data_addr_i[31:AW+2]};

`ifdef MIRISCV_DATA_RAM_BOUNDS_EN
    logic err_q;

    assign in_range = ~|data_addr_i[31:AW+2];

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            err_q <= 1'b0;
        end else if (accept && !in_range) begin
            err_q <= 1'b1;
        end
    end

    assign data_err_o = err_q;
`else
    assign in_range   = 1'b1;
    assign data_err_o = 1'b0;
`endif

    // Array is deliberately not reset; stores land at the acceptance edge even if reset follows.
    always_ff @(posedge clk_i) begin
        if (accept && data_we_i && in_range) begin
            for (int unsigned k = 0; k < 4; k++) begin
                if (data_be_i[k]) begin
                    mem[word_idx][8*k +: 8] <= data_wdata_i[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            rdata_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (data_req_i) begin
                        cnt   <= CNT_INIT;
                        state <= (LATENCY == 1) ? ST_RESP : ST_WAIT;
                        if (!data_we_i) begin
                            rdata_q <= in_range ? mem[word_idx] : '0;
                        end
                    end
                end
                ST_WAIT: begin
                    // Leave WAIT on the edge that takes the counter to 0, so RESP lands LATENCY-1 edges after acceptance.
                    cnt <= (cnt == 4'd0) ? 4'd0 : cnt - 4'd1;
                    if (cnt <= 4'd1) begin
                        state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign data_rvalid_o = (state == ST_RESP);
    assign data_rdata_o  = rdata_q;

endmodule

// File: tb/tb_miriscv_data_ram.sv
module tb_miriscv_data_ram;

  logic        clk;
  logic        rst    [3];
  logic        req    [3];
  logic        we     [3];
  logic [3:0]  be     [3];
  logic [31:0] addr   [3];
  logic [31:0] wdata  [3];
  logic        rvalid [3];
  logic [31:0] rdata  [3];
  logic        err    [3];

  int total  = 0;
  int passed = 0;
  int failed = 0;

  miriscv_data_ram #(.MEM_WORDS(1024), .LATENCY(1)) u_l1 (
    .clk_i(clk), .arst_i(rst[0]), .data_req_i(req[0]), .data_we_i(we[0]),
    .data_be_i(be[0]), .data_addr_i(addr[0]), .data_wdata_i(wdata[0]),
    .data_rvalid_o(rvalid[0]), .data_rdata_o(rdata[0]), .data_err_o(err[0])
  );

  miriscv_data_ram #(.MEM_WORDS(1024), .LATENCY(4)) u_l4 (
    .clk_i(clk), .arst_i(rst[1]), .data_req_i(req[1]), .data_we_i(we[1]),
    .data_be_i(be[1]), .data_addr_i(addr[1]), .data_wdata_i(wdata[1]),
    .data_rvalid_o(rvalid[1]), .data_rdata_o(rdata[1]), .data_err_o(err[1])
  );

  miriscv_data_ram #(.MEM_WORDS(1024), .LATENCY(3)) u_l3 (
    .clk_i(clk), .arst_i(rst[2]), .data_req_i(req[2]), .data_we_i(we[2]),
    .data_be_i(be[2]), .data_addr_i(addr[2]), .data_wdata_i(wdata[2]),
    .data_rvalid_o(rvalid[2]), .data_rdata_o(rdata[2]), .data_err_o(err[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic do_access(input int i, input logic w, input logic [3:0] b,
                           input logic [31:0] a, input logic [31:0] d,
                           output int lat, output logic [31:0] rd);
    @(posedge clk); #1;
    req[i] = 1'b1; we[i] = w; be[i] = b; addr[i] = a; wdata[i] = d;
    @(posedge clk); #1;
    req[i] = 1'b0; we[i] = 1'b0; be[i] = 4'h0; addr[i] = 32'hFFFF_FFFC; wdata[i] = 32'h0BAD_0BAD;
    lat = 0;
    rd  = 32'hXXXX_XXXX;
    for (int unsigned n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (rvalid[i] === 1'b1) begin
        lat = n;
        rd  = rdata[i];
        break;
      end
    end
  endtask

  initial begin
    int          lat;
    logic [31:0] rd;
    logic [19:0] pulses;
    logic        data_ok;
    logic        seen;

    for (int unsigned i = 0; i < 3; i++) begin
      rst[i] = 1'b1; req[i] = 1'b0; we[i] = 1'b0; be[i] = 4'h0;
      addr[i] = 32'h0; wdata[i] = 32'h0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int unsigned i = 0; i < 3; i++) rst[i] = 1'b0;

    for (int unsigned c = 0; c < 5; c++) begin
      @(negedge clk);
      total++;
      if ({rvalid[0], rdata[0], err[0]} !== 34'h0) begin
        failed++; $error("FAIL idle_l1 observed=%0h", {rvalid[0], rdata[0], err[0]});
      end else passed++;
    end
    total++;
    if ({rvalid[1], rdata[1], err[1]} !== 34'h0) begin
      failed++; $error("FAIL idle_l4 observed=%0h", {rvalid[1], rdata[1], err[1]});
    end else passed++;
    total++;
    if ({rvalid[2], rdata[2], err[2]} !== 34'h0) begin
      failed++; $error("FAIL idle_l3 observed=%0h", {rvalid[2], rdata[2], err[2]});
    end else passed++;

    do_access(0, 1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF, lat, rd);
    total++;
    if (lat !== 1) begin failed++; $error("FAIL st_lat1 observed=%0d", lat); end else passed++;
    total++;
    if (rd !== 32'h0) begin failed++; $error("FAIL st_rdata_held observed=%0h", rd); end else passed++;
    @(negedge clk);
    total++;
    if (rvalid[0] !== 1'b0) begin failed++; $error("FAIL st_single_pulse"); end else passed++;
    do_access(0, 1'b0, 4'h0, 32'h10, 32'h0, lat, rd);
    total++;
    if (lat !== 1) begin failed++; $error("FAIL ld_lat1 observed=%0d", lat); end else passed++;
    total++;
    if (rd !== 32'hDEAD_BEEF) begin failed++; $error("FAIL ld_data observed=%0h", rd); end else passed++;
    @(negedge clk);
    total++;
    if (rvalid[0] !== 1'b0) begin failed++; $error("FAIL ld_single_pulse"); end else passed++;
    repeat (2) @(negedge clk);
    total++;
    if (rdata[0] !== 32'hDEAD_BEEF) begin failed++; $error("FAIL ld_data_stable observed=%0h", rdata[0]); end else passed++;

    do_access(0, 1'b1, 4'h1, 32'h10, 32'h0000_00AA, lat, rd);
    total++;
    if (rd !== 32'hDEAD_BEEF) begin failed++; $error("FAIL bst0_rdata_held observed=%0h", rd); end else passed++;
    do_access(0, 1'b1, 4'h4, 32'h12, 32'h00CC_0000, lat, rd);
    total++;
    if (rd !== 32'hDEAD_BEEF) begin failed++; $error("FAIL bst2_rdata_held observed=%0h", rd); end else passed++;
    do_access(0, 1'b0, 4'h0, 32'h10, 32'h0, lat, rd);
    total++;
    if (rd !== 32'hDECC_BEAA) begin failed++; $error("FAIL bst_merge observed=%0h", rd); end else passed++;

    do_access(0, 1'b1, 4'h0, 32'h10, 32'h1111_1111, lat, rd);
    total++;
    if (lat !== 1) begin failed++; $error("FAIL be0_lat observed=%0d", lat); end else passed++;
    do_access(0, 1'b0, 4'h0, 32'h10, 32'h0, lat, rd);
    total++;
    if (rd !== 32'hDECC_BEAA) begin failed++; $error("FAIL be0_nochange observed=%0h", rd); end else passed++;

    do_access(1, 1'b1, 4'hF, 32'h0, 32'h1111_1111, lat, rd);
    total++;
    if (lat !== 4) begin failed++; $error("FAIL l4_st_lat observed=%0d", lat); end else passed++;
    do_access(1, 1'b1, 4'hF, 32'h4, 32'h2222_2222, lat, rd);
    total++;
    if (lat !== 4) begin failed++; $error("FAIL l4_st2_lat observed=%0d", lat); end else passed++;

    @(posedge clk); #1;
    req[1] = 1'b1; we[1] = 1'b0; be[1] = 4'hF; addr[1] = 32'h0; wdata[1] = 32'h0;
    pulses  = '0;
    data_ok = 1'b1;
    for (int unsigned c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if ((c % 5) < 2) begin
        we[1] = 1'b1; addr[1] = 32'h4; wdata[1] = 32'hBAD0_0000 + 32'(c);
      end else begin
        we[1] = 1'b0; addr[1] = 32'h0; wdata[1] = 32'h0;
      end
      @(negedge clk);
      pulses[c] = rvalid[1];
      if (rvalid[1] === 1'b1 && rdata[1] !== 32'h1111_1111) data_ok = 1'b0;
    end
    req[1] = 1'b0; we[1] = 1'b0;
    total++;
    if (pulses !== 20'b0100_0010_0001_0000_1000) begin
      failed++; $error("FAIL l4_pulse_pattern observed=%0b", pulses);
    end else passed++;
    total++;
    if (data_ok !== 1'b1) begin failed++; $error("FAIL l4_held_rdata"); end else passed++;
    do_access(1, 1'b0, 4'h0, 32'h4, 32'h0, lat, rd);
    total++;
    if (rd !== 32'h2222_2222) begin failed++; $error("FAIL l4_wait_store_ignored observed=%0h", rd); end else passed++;

    do_access(2, 1'b1, 4'hF, 32'h24, 32'hCAFE_F00D, lat, rd);
    total++;
    if (lat !== 3) begin failed++; $error("FAIL l3_st_lat observed=%0d", lat); end else passed++;
    do_access(2, 1'b0, 4'h0, 32'h24, 32'h0, lat, rd);
    total++;
    if (rd !== 32'hCAFE_F00D) begin failed++; $error("FAIL l3_ld_data observed=%0h", rd); end else passed++;
    @(posedge clk); #1;
    req[2] = 1'b1; we[2] = 1'b1; be[2] = 4'hF; addr[2] = 32'h20; wdata[2] = 32'h1234_5678;
    @(posedge clk); #1;
    req[2] = 1'b0; we[2] = 1'b0; be[2] = 4'h0;
    @(negedge clk);
    rst[2] = 1'b1;
    #1;
    total++;
    if ({rvalid[2], rdata[2], err[2]} !== 34'h0) begin
      failed++; $error("FAIL l3_reset_outputs observed=%0h", {rvalid[2], rdata[2], err[2]});
    end else passed++;
    seen = 1'b0;
    for (int unsigned c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 1) rst[2] = 1'b0;
      if (rvalid[2] === 1'b1) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin failed++; $error("FAIL l3_no_rvalid_after_reset"); end else passed++;
    do_access(2, 1'b0, 4'h0, 32'h20, 32'h0, lat, rd);
    total++;
    if (lat !== 3) begin failed++; $error("FAIL l3_post_reset_lat observed=%0d", lat); end else passed++;
    total++;
    if (rd !== 32'h1234_5678) begin failed++; $error("FAIL l3_store_survived observed=%0h", rd); end else passed++;

    do_access(0, 1'b1, 4'hF, 32'h0, 32'h5A5A_5A5A, lat, rd);
    do_access(0, 1'b0, 4'h0, 32'h1000, 32'h0, lat, rd);
    total++;
    if (lat !== 1) begin failed++; $error("FAIL oor_lat observed=%0d", lat); end else passed++;
`ifdef MIRISCV_DATA_RAM_BOUNDS_EN
    total++;
    if (rd !== 32'h0) begin failed++; $error("FAIL oor_rdata observed=%0h", rd); end else passed++;
    total++;
    if (err[0] !== 1'b1) begin failed++; $error("FAIL oor_err"); end else passed++;
    do_access(0, 1'b0, 4'h0, 32'h10, 32'h0, lat, rd);
    total++;
    if (err[0] !== 1'b1) begin failed++; $error("FAIL oor_err_sticky"); end else passed++;
    total++;
    if (rd !== 32'hDECC_BEAA) begin failed++; $error("FAIL oor_inrange_after observed=%0h", rd); end else passed++;
`else
    total++;
    if (rd !== 32'h5A5A_5A5A) begin failed++; $error("FAIL wrap_rdata observed=%0h", rd); end else passed++;
    total++;
    if (err[0] !== 1'b0) begin failed++; $error("FAIL wrap_err"); end else passed++;
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/miriscv_data_ram.md
# miriscv_data_ram

Behavioural data-memory responder for the miriscv core data interface (`data_req`/`data_we`/`data_be`/`data_addr`/`data_wdata` in, `data_rvalid`/`data_rdata` out). It sits on the memory side of the core's memory stage in simulation and FPGA top levels. It accepts one access at a time, performs byte-enabled writes or word reads on an internal array, and returns a single-cycle `data_rvalid_o` pulse after a programmable latency for every access, loads and stores alike.

## Interface
- `MEM_WORDS`, default 1024: array depth in 32-bit words; power of two, ≥ 4.
- `LATENCY`, default 1: cycles from request acceptance to the `data_rvalid_o` pulse; legal range 1..8.
- `clk_i`, input, 1: clock. All logic is rising-edge.
- `arst_i`, input, 1: reset, asynchronous, active-high.
- `data_req_i`, input, 1: access request.
- `data_we_i`, input, 1: 1 = store, 0 = load.
- `data_be_i`, input, XLEN/8: byte enables for stores; ignored for loads.
- `data_addr_i`, input, XLEN: byte address.
- `data_wdata_i`, input, XLEN: store data, byte lanes aligned to the word.
- `data_rvalid_o`, output, 1: one-cycle response pulse, for loads and stores.
- `data_rdata_o`, output, XLEN: load data, valid when `data_rvalid_o` = 1.
- `data_err_o`, output, 1: sticky out-of-range flag. Tied to 0 unless `MIRISCV_DATA_RAM_BOUNDS_EN` is defined.

## Operation
- Word index is `data_addr_i[log2(MEM_WORDS)+1:2]`.
- `data_addr_i[1:0]` is ignored; the core performs lane alignment.
- Without bounds checking, upper address bits are ignored, so addresses wrap modulo `MEM_WORDS*4`.
- FSM states:
  - IDLE: a request is accepted when `data_req_i` = 1. On acceptance, load the latency counter with `LATENCY-1` and go to WAIT.
  - WAIT: the counter decrements each cycle. When it is 0, go to RESP.
  - RESP: `data_rvalid_o` = 1 for exactly this cycle. `data_req_i` is ignored in RESP. Return to IDLE.
- With `LATENCY` = 1, WAIT is skipped: IDLE → RESP.
- Stores update the array at the acceptance edge, with per-byte writes where `data_be_i[k]` = 1. A store with `data_be_i` = 0 still produces a response.
- Loads sample the array word at the acceptance edge into a response register. A load therefore returns data including any store accepted earlier.
- `data_rdata_o` is driven from the response register:
  - Loads update the register; stores leave it unchanged.
  - The value is held stable between responses.
- Request fields (`data_we_i`, `data_be_i`, `data_addr_i`, `data_wdata_i`) are used only at the acceptance cycle. Later changes while in WAIT or RESP have no effect.
- Array contents are not reset. Simulation initial content is X unless preloaded with `$readmemh` from the top level.

## Timing
- Reset values:
  - `data_rvalid_o` = 0
  - `data_rdata_o` = 0
  - `data_err_o` = 0
  - FSM = IDLE
  - counter = 0
- Reset asserted mid-access: the pending response is dropped and no `data_rvalid_o` pulse follows. A store that was already accepted remains in the array.
- Request accepted at edge N → `data_rvalid_o` high in cycle N+`LATENCY`.
- Earliest next acceptance is edge N+`LATENCY`+1. Peak throughput is one access per `LATENCY`+1 cycles.
- A request held high across RESP (the core keeps `data_req_o` asserted until `rvalid`) is not re-accepted. A new access is accepted only if `data_req_i` is high in IDLE.
- Back-to-back: with `data_req_i` held high and `LATENCY` = 1, `data_rvalid_o` pulses every 2 cycles.

## Configuration
- `MIRISCV_DATA_RAM_BOUNDS_EN` defined:
  - Any access whose word address ≥ `MEM_WORDS` (any address bit above the index field set) is out of range.
  - Out-of-range stores are dropped.
  - Out-of-range loads return 0.
  - `data_err_o` is set at the acceptance edge and stays set until reset.
  - The response timing is unchanged.
- `MIRISCV_DATA_RAM_BOUNDS_EN` not defined:
  - Addresses wrap.
  - `data_err_o` is constant 0 and no compare logic is generated.

## Test plan
- Reset, then idle for 5 cycles → `data_rvalid_o` = 0, `data_rdata_o` = 0x00000000, `data_err_o` = 0 throughout.
- `LATENCY` = 1: store 0xDEADBEEF to 0x10 with be = 0xF, then load 0x10 → each access gets one `rvalid` pulse exactly 1 cycle after acceptance; the load returns 0xDEADBEEF.
- Byte stores: store 0x000000AA be = 0x1 and 0x00CC0000 be = 0x4 to 0x10 (previously 0xDEADBEEF), then load → 0xDECCBEAA; `data_rdata_o` is unchanged during the store responses.
- `LATENCY` = 4: `data_req_i` held high for 20 cycles with loads → `rvalid` exactly every 5 cycles; `addr`/`we` changes during WAIT are ignored.
- Assert `arst_i` in WAIT with `LATENCY` = 3 after a store of 0x12345678 to 0x20 → no `rvalid`; all outputs are 0. A load of 0x20 after reset returns 0x12345678.
- With `MEM_WORDS` = 1024: load 0x1000 → `BOUNDS_EN` defined: rdata 0 and `data_err_o` goes 1 and stays set; `BOUNDS_EN` undefined: the word at 0x0000 is returned and `data_err_o` = 0.
